prog_loader: RTL

- Upstream feeder for the single-cycle core's instruction memory write port (inst_we / inst_wr_addr / inst_wr_data).
- Accepts a byte stream over a valid/ready handshake, typically from a UART receiver or bench driver.
- Stream format: little-endian 32-bit word count, then that many little-endian instruction words. Each completed word is written to consecutive instruction addresses.
- Holds the core in reset during loading; releases it on successful completion.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_byte_packer.sv | 31 +++
 rtl/prog_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the instruction-memory program loader.
// REG_W covers both the 32-bit write address and the assembled instruction word.
package prog_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int REG_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian 8->32 packer; word_valid fires combinationally with the 4th accepted byte.
// The word output already includes the byte being accepted, so the consumer can register it directly.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              take,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [WORD_W-1:0] shift_q;
  logic [1:0]        cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= 2'd0;
    end else if (take) begin
      shift_q <= {byte_in, shift_q[WORD_W-1:BYTE_W]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign word       = {byte_in, shift_q[WORD_W-1:BYTE_W]};
  assign word_valid = take && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: reads a LE word count, then writes that many LE words to
// consecutive instruction addresses while holding the core in reset.
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready; byte_ready depends
// only on the registered state, and byte_valid may drop for any number of cycles.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              inst_we,
  output logic [REG_W-1:0]  inst_wr_addr,
  output logic [REG_W-1:0]  inst_wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output state_t            dbg_state
);

  localparam logic [REG_W-1:0] MAX_LEN = REG_W'(MEM_WORDS);

  state_t            state, state_nx;
  logic [REG_W-1:0]  addr_q, len_q, wcnt_q;
  logic              first_done_q;
  logic              take, sess_start, len_bad, last_word;
  logic [WORD_W-1:0] word;
  logic              word_valid;

  assign take       = byte_valid && byte_ready;
  assign sess_start = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign len_bad    = (word == '0) || (word > MAX_LEN);
  assign last_word  = (state == ST_LOAD) && word_valid && (wcnt_q == len_q - 32'd1);
  assign dbg_state  = state;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (sess_start),
    .take       (take),
    .byte_in    (byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_nx = ST_LEN;
      ST_LEN:  if (word_valid) state_nx = len_bad ? ST_ERROR : ST_LOAD;
      ST_LOAD: if (last_word) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Write port is registered: the strobe lands the cycle after a word's 4th byte,
  // which for the last word is the first DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= BASE_ADDR;
      len_q        <= '0;
      wcnt_q       <= '0;
      first_done_q <= 1'b0;
      inst_we      <= 1'b0;
      inst_wr_addr <= '0;
      inst_wr_data <= '0;
    end else begin
      inst_we      <= 1'b0;
      first_done_q <= last_word;
      if (sess_start) begin
        addr_q <= BASE_ADDR;
        len_q  <= '0;
        wcnt_q <= '0;
      end
      if (state == ST_LEN && word_valid && !len_bad) len_q <= word;
      if (state == ST_LOAD && word_valid) begin
        inst_we      <= 1'b1;
        inst_wr_addr <= addr_q;
        inst_wr_data <= word;
        addr_q       <= addr_q + 32'd4;
        wcnt_q       <= wcnt_q + 32'd1;
      end
    end
  end

  // cpu_hold stays up through the first DONE cycle so the core never runs during the last write.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b0;
    unique case (state)
      ST_LEN, ST_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
      end
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = first_done_q;
      end
      ST_ERROR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
